// File: rtl/tdm_demux.sv
// -----------------------------------------------------------------------------
// tdm_demux
//
// Receive end of a time-division multiplexed word stream. Each frame carries
// CHANNELS words; word 0 is flagged by in_sof. The block hunts for an in_sof,
// then steers every valid word into its channel's holding register, pulsing
// the matching out_valid bit. It also flags completed frames and alignment
// violations.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   in_data/in_sof meaningful this cycle
//   in_sof     word belongs to channel 0 (qualified by in_valid)
//   in_data    incoming word
//   out_data   per-channel holding registers, channel k at [k*WIDTH +: WIDTH]
//   out_valid  one-cycle pulse on bit k when channel k was written
//   frame_done one-cycle pulse when the last channel is written while locked
//   sync_err   one-cycle pulse on a missing or early in_sof
//   locked     high while frame alignment is held
// -----------------------------------------------------------------------------
module tdm_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_sof,
  input  logic [WIDTH-1:0]          in_data,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  output logic                      frame_done,
  output logic                      sync_err,
  output logic                      locked
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_ch;
  logic [CHANNELS-1:0]   out_valid_d;
  logic                  frame_done_d;
  logic                  sync_err_d;

  // Next-state and write-steering decode.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wr_en        = 1'b0;
    wr_ch        = '0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          // Non-sof words carry no alignment information and are dropped.
          if (in_sof) begin
            wr_en   = 1'b1;
            wr_ch   = '0;
            idx_d   = IDX_W'(1);
            state_d = LOCKED;
          end
        end

        LOCKED: begin
          if (in_sof) begin
            // Normal frame start, or an early sof that truncates the current
            // frame; either way the word is kept as the new channel 0.
            wr_en      = 1'b1;
            wr_ch      = '0;
            idx_d      = IDX_W'(1);
            sync_err_d = (idx_q != '0);
          end else if (idx_q == '0) begin
            // Frame boundary expected but sof missing: alignment lost.
            sync_err_d = 1'b1;
            state_d    = HUNT;
            idx_d      = '0;
          end else begin
            wr_en = 1'b1;
            wr_ch = idx_q;
            if (idx_q == LAST_IDX) begin
              frame_done_d = 1'b1;
              idx_d        = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end

        default: begin
          state_d = HUNT;
          idx_d   = '0;
        end
      endcase
    end

    for (int k = 0; k < CHANNELS; k++) begin
      out_valid_d[k] = wr_en && (wr_ch == IDX_W'(k));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      idx_q      <= '0;
      out_data   <= '0;
      out_valid  <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_valid  <= out_valid_d;
      frame_done <= frame_done_d;
      sync_err   <= sync_err_d;
      for (int k = 0; k < CHANNELS; k++) begin
        if (out_valid_d[k]) begin
          out_data[k*WIDTH +: WIDTH] <= in_data;
        end
      end
    end
  end

  // Decode of the state flop; rises with the first out_valid[0] pulse and
  // falls with the sync_err pulse for a missing sof.
  assign locked = (state_q == LOCKED);

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: the receive end of a single-line word stream that interleaves CHANNELS sources, word 0 of each frame flagged by in_sof.
- Hunts for frame alignment, steers each valid word into its channel's holding register, pulses per-channel valid strobes, and flags frame completion and sync errors.
- Sits downstream of the muxed datapath and feeds per-channel consumers.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- CHANNELS, 4, number of interleaved channels per frame (>=2). Channel index width is clog2(CHANNELS), internal.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_sof are meaningful this cycle.
- in_sof  input  1  qualified by in_valid; this word belongs to channel 0.
- in_data  input  WIDTH  incoming word.
- out_data  output  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]; registered, holds until overwritten.
- out_valid  output  CHANNELS  one-cycle pulse on bit k when channel k register was written.
- frame_done  output  1  one-cycle pulse when channel CHANNELS-1 is written in LOCKED.
- sync_err  output  1  one-cycle pulse on an alignment violation.
- locked  output  1  high while the FSM is in LOCKED.

Behaviour:
- Reset, asynchronous, any time, including mid-frame: out_data=0, out_valid=0, frame_done=0, sync_err=0, locked=0, state=HUNT, idx=0. A partial frame is abandoned; no pulses are generated for it.
- All outputs are registered. Effects of an accepted word appear on the cycle after the clk edge that samples it, giving latency 1. The block has no backpressure and accepts every word.
- in_sof is ignored when in_valid=0. Cycles with in_valid=0 change nothing: idx holds and pulses return to 0.
- HUNT:
  - in_valid & ~in_sof: word dropped, no output activity, stay HUNT.
  - in_valid & in_sof: write channel 0, pulse out_valid[0], set idx=1, go LOCKED.
- LOCKED, in_valid & ~in_sof:
  - idx!=0: write channel idx, pulse out_valid[idx].
    - If idx==CHANNELS-1, also pulse frame_done and wrap idx to 0.
    - Otherwise idx=idx+1.
  - idx==0: a frame boundary was expected but sof is missing. Pulse sync_err, drop the word, go HUNT, idx=0.
- LOCKED, in_valid & in_sof:
  - idx==0: normal new frame. Write channel 0, pulse out_valid[0], idx=1.
  - idx!=0: early sof, resync. Pulse sync_err and write channel 0 with this word (pulse out_valid[0]), then idx=1, stay LOCKED. The truncated frame produces no frame_done.
- Pulse exclusivity: at most one out_valid bit is high in any cycle. frame_done coincides only with out_valid[CHANNELS-1]. sync_err may coincide with out_valid[0] (early sof case).
- Channels not written in a cycle keep their previous out_data value.
- locked reflects the registered state: it rises in the cycle out_valid[0] first pulses and falls in the cycle sync_err pulses for a missing sof.

Test Plan (WIDTH=8, CHANNELS=4):
- Reset, then valid words 0x11,0x22 with sof=0 -> no out_valid, locked=0, out_data=0.
- sof+0xA0, then 0xA1,0xA2,0xA3 on consecutive cycles -> out_valid pulses 0001,0010,0100,1000 on cycles 1-4 after each word; frame_done with the last; out_data=0xA3A2A1A0; locked=1.
- Full frame 0xB0..0xB3 with in_valid gaps of 2 idle cycles between words -> same outputs as above, one frame_done, channel values held across gaps.
- After a frame, valid 0xC0 with sof=0 -> sync_err pulse, locked=0, out_data unchanged; next sof+0xD0 -> out_valid[0], locked=1.
- sof+0xE0, 0xE1, then sof+0xF0 -> sync_err and out_valid[0] together, ch0=0xF0, ch1=0xE1, no frame_done; then 0xF1,0xF2,0xF3 -> frame_done.
- Assert rst after 2 words of a frame -> all outputs 0 immediately (before next edge), locked=0; a subsequent non-sof word is dropped.
